// File: rtl/cu_mc_param_if.sv
// Control-unit bus: datapath status and memory handshake in, control word out.
// Handshake: mem_req is the valid; the CU holds it and the address/write controls steady
// until a cycle with mem_rdy=1 completes the transfer; mem_rdy is ignored while mem_req=0.
interface cu_mc_param_if #(
  parameter int DW    = 16,
  parameter int RAW   = 3,
  parameter int CNT_W = 16
);
  logic [DW-1:0]    IR;
  logic             N;
  logic             Z;
  logic             C;
  logic             mem_rdy;
  logic             resume;
  logic [RAW-1:0]   W_Adr;
  logic [RAW-1:0]   R_Adr;
  logic [RAW-1:0]   S_Adr;
  logic             adr_sel;
  logic             s_sel;
  logic             pc_ld;
  logic             pc_inc;
  logic             pc_sel;
  logic             ir_ld;
  logic             mw_en;
  logic             rw_en;
  logic [3:0]       alu_op;
  logic             mem_req;
  logic             illegal;
  logic [CNT_W-1:0] instr_cnt;
  logic [7:0]       status;

  modport master (
    input  IR, N, Z, C, mem_rdy, resume,
    output W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld,
           mw_en, rw_en, alu_op, mem_req, illegal, instr_cnt, status
  );

  modport slave (
    output IR, N, Z, C, mem_rdy, resume,
    input  W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld,
           mw_en, rw_en, alu_op, mem_req, illegal, instr_cnt, status
  );
endinterface

// File: rtl/cu_mc_param.sv
// Multi-cycle control unit for the 301 RISC family: fetch/decode/execute FSM with
// memory wait states, resumable HALT, illegal-opcode trap and retired-instruction counter.
module cu_mc_param #(
  parameter int             DW      = 16,
  parameter int             OPW     = 7,
  parameter int             RAW     = 3,
  parameter logic [OPW-1:0] OP_BASE = 7'h70,
  parameter int             CNT_W   = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  cu_mc_param_if.master  bus,
  output logic [4:0]     dbg_state
);

  // Execute states occupy 0..15 so the state value doubles as the status code.
  typedef enum logic [4:0] {
    S_ADD = 5'd0, S_SUB, S_CMP, S_MOV, S_SHL, S_SHR, S_INC, S_DEC,
    S_LD, S_STO, S_LDI, S_HALT, S_JE, S_JNE, S_JC, S_JMP,
    S_RESET, S_FETCH, S_DECODE, S_ILLEGAL
  } state_t;

  state_t           state;
  logic [2:0]       ps;
  logic [CNT_W-1:0] cnt;

  logic [OPW-1:0] opcode;
  logic [OPW-1:0] op_off;
  logic           op_valid;
  logic [RAW-1:0] w_f, r_f, s_f;
  logic           retire;

  assign opcode   = bus.IR[DW-1 -: OPW];
  assign op_off   = opcode - OP_BASE;
  assign op_valid = (op_off[OPW-1:4] == '0);
  assign w_f      = bus.IR[3*RAW-1 -: RAW];
  assign r_f      = bus.IR[2*RAW-1 -: RAW];
  assign s_f      = bus.IR[RAW-1:0];

  assign dbg_state     = state;
  assign bus.instr_cnt = cnt;

  // HALT retires on the decode edge that enters it, so it counts exactly once.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_ADD, S_SUB, S_CMP, S_MOV, S_SHL, S_SHR, S_INC, S_DEC,
      S_JE, S_JNE, S_JC, S_JMP:  retire = 1'b1;
      S_LD, S_STO, S_LDI:        retire = bus.mem_rdy;
      S_DECODE:                  retire = op_valid && (op_off[3:0] == 4'd11);
      default:                   retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RESET;
      ps    <= 3'b000;
      cnt   <= '0;
    end else begin
      if (retire) cnt <= cnt + 1'b1;
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  if (bus.mem_rdy) state <= S_DECODE;
        S_DECODE: state <= op_valid ? state_t'({1'b0, op_off[3:0]}) : S_ILLEGAL;
        S_ADD, S_SUB, S_CMP, S_SHL, S_SHR, S_INC, S_DEC: begin
          ps    <= {bus.N, bus.Z, bus.C};
          state <= S_FETCH;
        end
        S_MOV, S_JE, S_JNE, S_JC, S_JMP: state <= S_FETCH;
        S_LD, S_STO, S_LDI: if (bus.mem_rdy) state <= S_FETCH;
        S_HALT:    if (bus.resume) state <= S_FETCH;
        S_ILLEGAL: ps <= 3'b000;
        default:   state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    bus.W_Adr   = '0;
    bus.R_Adr   = '0;
    bus.S_Adr   = '0;
    bus.adr_sel = 1'b0;
    bus.s_sel   = 1'b0;
    bus.pc_ld   = 1'b0;
    bus.pc_inc  = 1'b0;
    bus.pc_sel  = 1'b0;
    bus.ir_ld   = 1'b0;
    bus.mw_en   = 1'b0;
    bus.rw_en   = 1'b0;
    bus.alu_op  = 4'd0;
    bus.mem_req = 1'b0;
    bus.illegal = 1'b0;
    bus.status  = {ps, 1'b0, state[3:0]};
    case (state)
      S_RESET:  bus.status = 8'hFF;
      S_FETCH: begin
        bus.status  = 8'h80;
        bus.mem_req = 1'b1;
        bus.ir_ld   = bus.mem_rdy;
        bus.pc_inc  = bus.mem_rdy;
      end
      S_DECODE: bus.status = 8'hC0;
      S_ADD, S_SUB, S_CMP, S_MOV, S_SHL, S_SHR, S_INC, S_DEC: begin
        bus.W_Adr = w_f;
        bus.R_Adr = r_f;
        bus.S_Adr = s_f;
        bus.rw_en = (state != S_CMP);
        case (state)
          S_ADD:   bus.alu_op = 4'd4;
          S_SUB:   bus.alu_op = 4'd5;
          S_SHL:   bus.alu_op = 4'd7;
          S_SHR:   bus.alu_op = 4'd6;
          S_INC:   bus.alu_op = 4'd2;
          S_DEC:   bus.alu_op = 4'd3;
          default: bus.alu_op = 4'd0;
        endcase
      end
      S_LD: begin
        bus.adr_sel = 1'b1;
        bus.s_sel   = 1'b1;
        bus.W_Adr   = w_f;
        bus.R_Adr   = s_f;
        bus.mem_req = 1'b1;
        bus.rw_en   = bus.mem_rdy;
      end
      S_STO: begin
        bus.adr_sel = 1'b1;
        bus.R_Adr   = w_f;
        bus.S_Adr   = s_f;
        bus.mem_req = 1'b1;
        bus.mw_en   = 1'b1;
      end
      S_LDI: begin
        bus.s_sel   = 1'b1;
        bus.W_Adr   = w_f;
        bus.mem_req = 1'b1;
        bus.rw_en   = bus.mem_rdy;
        bus.pc_inc  = bus.mem_rdy;
      end
      S_JE:  bus.pc_ld = ps[1];
      S_JNE: bus.pc_ld = ~ps[1];
      S_JC:  bus.pc_ld = ps[0];
      S_JMP: begin
        bus.S_Adr  = s_f;
        bus.pc_ld  = 1'b1;
        bus.pc_sel = 1'b1;
      end
      S_ILLEGAL: begin
        bus.illegal = 1'b1;
        bus.status  = 8'hF0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cu_mc_param.sv
// Directed bench for cu_mc_param: driver pushes hand-computed output words per cycle,
// a negedge monitor pops and compares them against the live control word.
module tb_cu_mc_param;
  localparam int DW    = 16;
  localparam int RAW   = 3;
  localparam int CNT_W = 4;
  localparam int OBS_W = 35;

  localparam logic [7:0] C_RW    = 8'h80;
  localparam logic [7:0] C_MW    = 8'h40;
  localparam logic [7:0] C_IRLD  = 8'h20;
  localparam logic [7:0] C_PCINC = 8'h10;
  localparam logic [7:0] C_PCLD  = 8'h08;
  localparam logic [7:0] C_PCSEL = 8'h04;
  localparam logic [7:0] C_SSEL  = 8'h02;
  localparam logic [7:0] C_ADR   = 8'h01;
  localparam logic [OBS_W-1:0] FULL = {OBS_W{1'b1}};

  localparam logic [15:0] IR_ADD  = 16'hE0D1;
  localparam logic [15:0] IR_JE   = 16'hF800;
  localparam logic [15:0] IR_STO  = 16'hF346;
  localparam logic [15:0] IR_HALT = 16'hF600;
  localparam logic [15:0] IR_LD   = 16'hF053;
  localparam logic [15:0] IR_ILL  = 16'h2000;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [4:0] dbg_state;
  cu_mc_param_if #(.DW(DW), .RAW(RAW), .CNT_W(CNT_W)) bus ();
  cu_mc_param #(.DW(DW), .OPW(7), .RAW(RAW), .OP_BASE(7'h70), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .dbg_state(dbg_state)
  );

  logic [OBS_W-1:0] obs;
  assign obs = {bus.status, bus.instr_cnt, bus.illegal, bus.mem_req, bus.alu_op,
                bus.rw_en, bus.mw_en, bus.ir_ld, bus.pc_inc, bus.pc_ld, bus.pc_sel,
                bus.s_sel, bus.adr_sel, bus.W_Adr, bus.R_Adr, bus.S_Adr};

  // scoreboard
  logic [OBS_W-1:0] exp_q[$];
  logic [OBS_W-1:0] msk_q[$];
  string            name_q[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [OBS_W-1:0] mk(input logic [7:0] st, input logic [3:0] cnt,
                                          input logic ill, input logic req,
                                          input logic [3:0] op, input logic [7:0] ctl,
                                          input logic [2:0] w, input logic [2:0] r,
                                          input logic [2:0] s);
    return {st, cnt, ill, req, op, ctl, w, r, s};
  endfunction

  always @(negedge clk) begin : monitor
    logic [OBS_W-1:0] e, m;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      m  = msk_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (((obs ^ e) & m) != '0) begin
        errors++;
        $display("FAIL %s: got %h want %h mask %h (state=%0d, t=%0t)",
                 nm, obs, e, m, dbg_state, $time);
      end
    end
  end

  // driver tasks
  task automatic cyc(input logic rn, input logic [15:0] ir, input logic [2:0] nzc,
                     input logic rdy, input logic res, input logic [OBS_W-1:0] e,
                     input logic [OBS_W-1:0] m, input string nm);
    reset_n     = rn;
    bus.IR      = ir;
    {bus.N, bus.Z, bus.C} = nzc;
    bus.mem_rdy = rdy;
    bus.resume  = res;
    if (m != '0) begin
      exp_q.push_back(e);
      msk_q.push_back(m);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [15:0] ir, input logic [3:0] cnt);
    cyc(1'b1, ir, 3'b000, 1'b1, 1'b0,
        mk(8'h80, cnt, 1'b0, 1'b1, 4'd0, C_IRLD | C_PCINC, 3'd0, 3'd0, 3'd0), FULL, "fetch");
    cyc(1'b1, ir, 3'b000, 1'b0, 1'b0,
        mk(8'hC0, cnt, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 3'd0, 3'd0), FULL, "decode");
  endtask

  logic [15:0]      t_ir[13];
  logic [2:0]       t_nzc[13];
  logic [OBS_W-1:0] t_exp[13];

  initial begin
    logic [OBS_W-1:0] rst_w;
    rst_w = mk(8'hFF, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 3'd0, 3'd0);

    t_ir[0]  = 16'hE253; t_nzc[0]  = 3'b100; t_exp[0]  = mk(8'h61, 4'd4,  1'b0, 1'b0, 4'd5, C_RW, 3'd1, 3'd2, 3'd3);
    t_ir[1]  = 16'hE453; t_nzc[1]  = 3'b001; t_exp[1]  = mk(8'h82, 4'd5,  1'b0, 1'b0, 4'd0, 8'h00, 3'd1, 3'd2, 3'd3);
    t_ir[2]  = 16'hE653; t_nzc[2]  = 3'b110; t_exp[2]  = mk(8'h23, 4'd6,  1'b0, 1'b0, 4'd0, C_RW, 3'd1, 3'd2, 3'd3);
    t_ir[3]  = 16'hE853; t_nzc[3]  = 3'b010; t_exp[3]  = mk(8'h24, 4'd7,  1'b0, 1'b0, 4'd7, C_RW, 3'd1, 3'd2, 3'd3);
    t_ir[4]  = 16'hEA53; t_nzc[4]  = 3'b000; t_exp[4]  = mk(8'h45, 4'd8,  1'b0, 1'b0, 4'd6, C_RW, 3'd1, 3'd2, 3'd3);
    t_ir[5]  = 16'hEC53; t_nzc[5]  = 3'b101; t_exp[5]  = mk(8'h06, 4'd9,  1'b0, 1'b0, 4'd2, C_RW, 3'd1, 3'd2, 3'd3);
    t_ir[6]  = 16'hEE53; t_nzc[6]  = 3'b011; t_exp[6]  = mk(8'hA7, 4'd10, 1'b0, 1'b0, 4'd3, C_RW, 3'd1, 3'd2, 3'd3);
    t_ir[7]  = 16'hFA53; t_nzc[7]  = 3'b000; t_exp[7]  = mk(8'h6D, 4'd11, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 3'd0, 3'd0);
    t_ir[8]  = 16'hFC53; t_nzc[8]  = 3'b000; t_exp[8]  = mk(8'h6E, 4'd12, 1'b0, 1'b0, 4'd0, C_PCLD, 3'd0, 3'd0, 3'd0);
    t_ir[9]  = 16'hF453; t_nzc[9]  = 3'b000; t_exp[9]  = mk(8'h6A, 4'd13, 1'b0, 1'b1, 4'd0, C_RW | C_PCINC | C_SSEL, 3'd1, 3'd0, 3'd0);
    t_ir[10] = 16'hF053; t_nzc[10] = 3'b000; t_exp[10] = mk(8'h68, 4'd14, 1'b0, 1'b1, 4'd0, C_RW | C_SSEL | C_ADR, 3'd1, 3'd3, 3'd0);
    t_ir[11] = 16'hFE53; t_nzc[11] = 3'b000; t_exp[11] = mk(8'h6F, 4'd15, 1'b0, 1'b0, 4'd0, C_PCLD | C_PCSEL, 3'd0, 3'd0, 3'd3);
    t_ir[12] = 16'hF853; t_nzc[12] = 3'b000; t_exp[12] = mk(8'h6C, 4'd0,  1'b0, 1'b0, 4'd0, C_PCLD, 3'd0, 3'd0, 3'd0);

    reset_n = 1'b0; bus.IR = '0; bus.N = 1'b0; bus.Z = 1'b0; bus.C = 1'b0;
    bus.mem_rdy = 1'b0; bus.resume = 1'b0;
    @(posedge clk);
    #1;

    cyc(1'b0, 16'h0000, 3'b000, 1'b0, 1'b0, rst_w, FULL, "reset_held");
    cyc(1'b1, IR_ADD, 3'b000, 1'b0, 1'b0, rst_w, FULL, "reset_state");

    for (int i = 0; i < 3; i++)
      cyc(1'b1, IR_ADD, 3'b000, 1'b0, 1'b0,
          mk(8'h80, 4'd0, 1'b0, 1'b1, 4'd0, 8'h00, 3'd0, 3'd0, 3'd0), FULL, "fetch_wait");
    cyc(1'b1, IR_ADD, 3'b000, 1'b1, 1'b0,
        mk(8'h80, 4'd0, 1'b0, 1'b1, 4'd0, C_IRLD | C_PCINC, 3'd0, 3'd0, 3'd0), FULL, "fetch_done");
    cyc(1'b1, IR_ADD, 3'b000, 1'b0, 1'b0,
        mk(8'hC0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 3'd0, 3'd0), FULL, "decode_add");
    cyc(1'b1, IR_ADD, 3'b011, 1'b0, 1'b0,
        mk(8'h00, 4'd0, 1'b0, 1'b0, 4'd4, C_RW, 3'd3, 3'd2, 3'd1), FULL, "add");

    fetch_decode(IR_JE, 4'd1);
    cyc(1'b1, IR_JE, 3'b000, 1'b0, 1'b0,
        mk(8'h6C, 4'd1, 1'b0, 1'b0, 4'd0, C_PCLD, 3'd0, 3'd0, 3'd0), FULL, "je_taken");

    fetch_decode(IR_STO, 4'd2);
    for (int i = 0; i < 2; i++)
      cyc(1'b1, IR_STO, 3'b000, 1'b0, 1'b0,
          mk(8'h69, 4'd2, 1'b0, 1'b1, 4'd0, C_MW | C_ADR, 3'd0, 3'd5, 3'd6), FULL, "sto_wait");
    cyc(1'b1, IR_STO, 3'b000, 1'b1, 1'b0,
        mk(8'h69, 4'd2, 1'b0, 1'b1, 4'd0, C_MW | C_ADR, 3'd0, 3'd5, 3'd6), FULL, "sto_done");

    fetch_decode(IR_HALT, 4'd3);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, IR_HALT, 3'b100, 1'b0, 1'b0,
          mk(8'h6B, 4'd4, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 3'd0, 3'd0), FULL, "halt_hold");
    cyc(1'b1, IR_HALT, 3'b100, 1'b0, 1'b1,
        mk(8'h6B, 4'd4, 1'b0, 1'b0, 4'd0, 8'h00, 3'd0, 3'd0, 3'd0), FULL, "halt_resume");

    for (int i = 0; i < 13; i++) begin
      fetch_decode(t_ir[i], t_exp[i][26:23]);
      cyc(1'b1, t_ir[i], t_nzc[i], 1'b1, 1'b0, t_exp[i], FULL, $sformatf("exec_%0d", i));
    end

    fetch_decode(IR_LD, 4'd1);
    for (int i = 0; i < 2; i++)
      cyc(1'b1, IR_LD, 3'b000, 1'b0, 1'b0,
          mk(8'h68, 4'd1, 1'b0, 1'b1, 4'd0, C_SSEL | C_ADR, 3'd1, 3'd3, 3'd0), FULL, "ld_wait");
    cyc(1'b0, IR_LD, 3'b000, 1'b0, 1'b0, rst_w, FULL, "reset_mid_ld");

    cyc(1'b1, IR_ILL, 3'b111, 1'b0, 1'b0, rst_w, FULL, "reset_state2");
    fetch_decode(IR_ILL, 4'd0);
    for (int i = 0; i < 20; i++)
      cyc(1'b1, IR_ILL, 3'b111, 1'b1, 1'b1,
          mk(8'hF0, 4'd0, 1'b1, 1'b0, 4'd0, 8'h00, 3'd0, 3'd0, 3'd0), FULL, "illegal_hold");
    cyc(1'b0, IR_ILL, 3'b000, 1'b0, 1'b0, rst_w, FULL, "illegal_reset");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d unchecked entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
